// File: rtl/sample1_demux.sv
// rtl/sample1_demux.sv - 1-to-4 stream demultiplexer with per-channel holding registers and drain counters
module sample1_demux #(
  parameter int WIDTH = 8
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [1:0]         S_IN,
  input  logic [WIDTH-1:0]   D_IN,
  input  logic               VALID_IN,
  output logic               READY_IN,
  output logic [4*WIDTH-1:0] Z,
  output logic [3:0]         VALID_OUT,
  input  logic [3:0]         READY_OUT,
  output logic [31:0]        CNT
);

  logic [3:0]       full;
  logic [3:0]       drain;
  logic [WIDTH-1:0] hold [4];
  logic [7:0]       cnt  [4];
  logic             accept;

  assign drain     = full & READY_OUT;
  // A channel may drain and refill in the same cycle, so only the addressed
  // channel's own stall can block the input.
  assign READY_IN  = !full[S_IN] || READY_OUT[S_IN];
  assign accept    = VALID_IN && READY_IN;
  assign VALID_OUT = full;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      full <= '0;
      for (int x = 0; x < 4; x++) begin
        hold[x] <= '0;
        cnt[x]  <= '0;
      end
    end else begin
      for (int x = 0; x < 4; x++) begin
        if (drain[x]) begin
          cnt[x] <= cnt[x] + 8'd1;
        end
        if (accept && (S_IN == 2'(x))) begin
          hold[x] <= D_IN;
          full[x] <= 1'b1;
        end else if (drain[x]) begin
          full[x] <= 1'b0;
        end
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_out
    assign Z[g*WIDTH +: WIDTH] = hold[g];
    assign CNT[g*8 +: 8]       = cnt[g];
  end

endmodule

// File: tb/tb_sample1_demux.sv
// tb/tb_sample1_demux.sv - randomized and directed checks of sample1_demux against a queue-based channel model
module tb_sample1_demux;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [1:0]  S_IN;
  logic [7:0]  D_IN;
  logic        VALID_IN;
  logic        READY_IN;
  logic [31:0] Z;
  logic [3:0]  VALID_OUT;
  logic [3:0]  READY_OUT;
  logic [31:0] CNT;

  int checks = 0;
  int errors = 0;

  // Model: each channel is a queue of capacity one plus a delivered count.
  logic [7:0] m_q   [4][$];
  logic [7:0] m_last[4];
  int         m_cnt [4];
  logic [7:0] acc   [4][$];
  logic [7:0] got   [4][$];
  logic       rdy_dut;
  logic       rdy_exp;

  sample1_demux #(.WIDTH(8)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .S_IN      (S_IN),
    .D_IN      (D_IN),
    .VALID_IN  (VALID_IN),
    .READY_IN  (READY_IN),
    .Z         (Z),
    .VALID_OUT (VALID_OUT),
    .READY_OUT (READY_OUT),
    .CNT       (CNT)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] exp_z();
    logic [31:0] r;
    for (int x = 0; x < 4; x++) r[x*8 +: 8] = m_last[x];
    return r;
  endfunction

  function automatic logic [3:0] exp_v();
    logic [3:0] r;
    for (int x = 0; x < 4; x++) r[x] = (m_q[x].size() != 0);
    return r;
  endfunction

  function automatic logic [31:0] exp_cnt();
    logic [31:0] r;
    for (int x = 0; x < 4; x++) r[x*8 +: 8] = 8'(m_cnt[x]);
    return r;
  endfunction

  task automatic cycle(input logic rst, input logic [1:0] s, input logic [7:0] d,
                       input logic v, input logic [3:0] ro);
    logic [3:0] dr;
    @(negedge CLK);
    RST_N = rst; S_IN = s; D_IN = d; VALID_IN = v; READY_OUT = ro;
    #1;
    rdy_dut = READY_IN;
    rdy_exp = (m_q[s].size() == 0) || ro[s];
    if (rst) begin
      for (int x = 0; x < 4; x++)
        if (VALID_OUT[x] === 1'b1 && ro[x]) got[x].push_back(Z[x*8 +: 8]);
      for (int x = 0; x < 4; x++) dr[x] = (m_q[x].size() != 0) && ro[x];
      for (int x = 0; x < 4; x++) begin
        if (dr[x]) begin
          void'(m_q[x].pop_front());
          m_cnt[x] = (m_cnt[x] + 1) % 256;
        end
      end
      if (v && rdy_exp) begin
        m_q[s].push_back(d);
        acc[s].push_back(d);
        m_last[s] = d;
      end
    end else begin
      for (int x = 0; x < 4; x++) begin
        if (m_q[x].size() != 0 && acc[x].size() != 0) void'(acc[x].pop_back());
        m_q[x].delete();
        m_last[x] = 8'h00;
        m_cnt[x]  = 0;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_logs();
    for (int x = 0; x < 4; x++) begin
      acc[x].delete();
      got[x].delete();
    end
  endtask

  task automatic test_reset();
    cycle(1'b0, 2'd0, 8'hFF, 1'b1, 4'hF);
    cycle(1'b0, 2'd2, 8'hEE, 1'b1, 4'hF);
    checks++;
    if ({VALID_OUT, Z, CNT} !== 68'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", {VALID_OUT, Z, CNT});
    end
    for (int s = 0; s < 4; s++) begin
      cycle(1'b1, 2'(s), 8'h00, 1'b0, 4'h0);
      checks++;
      if (rdy_dut !== 1'b1) begin
        errors++;
        $display("FAIL reset_ready[%0d]: got %b expected 1", s, rdy_dut);
      end
    end
    clear_logs();
  endtask

  task automatic test_routing();
    logic [7:0] data [4];
    data[0] = 8'hA5; data[1] = 8'h3C; data[2] = 8'hF0; data[3] = 8'h0F;
    clear_logs();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) cycle(1'b1, 2'(i), data[i], 1'b1, 4'hF);
      else       cycle(1'b1, 2'd0, 8'h00, 1'b0, 4'hF);
      checks++;
      if ({rdy_dut, VALID_OUT, Z, CNT} !== {rdy_exp, exp_v(), exp_z(), exp_cnt()}) begin
        errors++;
        $display("FAIL routing_state[%0d]: got %h expected %h", i,
                 {rdy_dut, VALID_OUT, Z, CNT}, {rdy_exp, exp_v(), exp_z(), exp_cnt()});
      end
      if (i < 4) begin
        checks++;
        if (VALID_OUT !== (4'b0001 << i) || Z[i*8 +: 8] !== data[i]) begin
          errors++;
          $display("FAIL routing_slice[%0d]: got valid %b data %h expected valid %b data %h",
                   i, VALID_OUT, Z[i*8 +: 8], 4'b0001 << i, data[i]);
        end
      end
    end
    checks++;
    if (CNT !== 32'h01010101) begin
      errors++;
      $display("FAIL routing_cnt: got %h expected 01010101", CNT);
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] ts [6];
    logic [7:0] td [6];
    logic       tv [6];
    logic [3:0] tr [6];
    ts = '{2'd1, 2'd1, 2'd2, 2'd0, 2'd1, 2'd0};
    td = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h22, 8'h00};
    tv = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tr = '{4'b1101, 4'b1101, 4'b1101, 4'b1101, 4'b1111, 4'b1111};
    clear_logs();
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, ts[i], td[i], tv[i], tr[i]);
      checks++;
      if ({rdy_dut, VALID_OUT, Z, CNT} !== {rdy_exp, exp_v(), exp_z(), exp_cnt()}) begin
        errors++;
        $display("FAIL backpressure_state[%0d]: got %h expected %h", i,
                 {rdy_dut, VALID_OUT, Z, CNT}, {rdy_exp, exp_v(), exp_z(), exp_cnt()});
      end
      if (i == 1) begin
        checks++;
        if (rdy_dut !== 1'b0 || Z[15:8] !== 8'h11 || VALID_OUT[1] !== 1'b1) begin
          errors++;
          $display("FAIL backpressure_stall: got ready %b b %h valid %b expected ready 0 b 11 valid 1",
                   rdy_dut, Z[15:8], VALID_OUT[1]);
        end
      end
      if (i == 2) begin
        checks++;
        if (rdy_dut !== 1'b1 || Z[23:16] !== 8'h33 || VALID_OUT[2] !== 1'b1) begin
          errors++;
          $display("FAIL backpressure_other: got ready %b c %h valid %b expected ready 1 c 33 valid 1",
                   rdy_dut, Z[23:16], VALID_OUT[2]);
        end
      end
    end
    checks++;
    if (got[1].size() != 2 || got[1][0] !== 8'h11 || got[1][1] !== 8'h22 ||
        got[2].size() != 1 || got[2][0] !== 8'h33) begin
      errors++;
      $display("FAIL backpressure_order: got b_count %0d c_count %0d expected b 11,22 and c 33",
               got[1].size(), got[2].size());
    end
  endtask

  task automatic test_streaming();
    cycle(1'b0, 2'd0, 8'h00, 1'b0, 4'h0);
    clear_logs();
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 2'd3, 8'(i), 1'b1, 4'b1000);
      checks++;
      if (rdy_dut !== 1'b1 || VALID_OUT[3] !== 1'b1 || Z[31:24] !== 8'(i) ||
          {VALID_OUT, Z, CNT} !== {exp_v(), exp_z(), exp_cnt()}) begin
        errors++;
        $display("FAIL streaming[%0d]: got ready %b state %h expected ready 1 d %h state %h",
                 i, rdy_dut, {VALID_OUT, Z, CNT}, 8'(i), {exp_v(), exp_z(), exp_cnt()});
      end
    end
    cycle(1'b1, 2'd0, 8'h00, 1'b0, 4'b1000);
    checks++;
    if (CNT[31:24] !== 8'd10 || VALID_OUT[3] !== 1'b0) begin
      errors++;
      $display("FAIL streaming_cnt: got %0d valid %b expected 10 valid 0", CNT[31:24], VALID_OUT[3]);
    end
  endtask

  task automatic test_wrap();
    cycle(1'b0, 2'd0, 8'h00, 1'b0, 4'h0);
    clear_logs();
    for (int i = 0; i < 256; i++) begin
      cycle(1'b1, 2'd0, 8'($urandom), 1'b1, 4'hF);
      checks++;
      if ({rdy_dut, VALID_OUT, Z, CNT} !== {rdy_exp, exp_v(), exp_z(), exp_cnt()}) begin
        errors++;
        $display("FAIL wrap_state[%0d]: got %h expected %h", i,
                 {rdy_dut, VALID_OUT, Z, CNT}, {rdy_exp, exp_v(), exp_z(), exp_cnt()});
      end
    end
    cycle(1'b1, 2'd0, 8'h00, 1'b0, 4'hF);
    checks++;
    if (CNT[7:0] !== 8'd0) begin
      errors++;
      $display("FAIL wrap_256: got %0d expected 0", CNT[7:0]);
    end
    cycle(1'b1, 2'd0, 8'h77, 1'b1, 4'hF);
    cycle(1'b1, 2'd0, 8'h00, 1'b0, 4'hF);
    checks++;
    if (CNT[7:0] !== 8'd1) begin
      errors++;
      $display("FAIL wrap_257: got %0d expected 1", CNT[7:0]);
    end
  endtask

  task automatic test_mid_reset();
    cycle(1'b0, 2'd0, 8'h00, 1'b0, 4'h0);
    clear_logs();
    cycle(1'b1, 2'd0, 8'h5A, 1'b1, 4'b1110);
    cycle(1'b1, 2'd0, 8'h00, 1'b0, 4'b1110);
    checks++;
    if (VALID_OUT[0] !== 1'b1 || Z[7:0] !== 8'h5A) begin
      errors++;
      $display("FAIL mid_reset_hold: got valid %b a %h expected valid 1 a 5a", VALID_OUT[0], Z[7:0]);
    end
    cycle(1'b0, 2'd1, 8'h77, 1'b1, 4'b1110);
    checks++;
    if (VALID_OUT !== 4'h0 || Z !== 32'h0 || CNT !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_clear: got %h expected 0", {VALID_OUT, Z, CNT});
    end
    for (int i = 0; i < 3; i++) cycle(1'b1, 2'd0, 8'h00, 1'b0, 4'hF);
    checks++;
    if (got[0].size() != 0 || got[1].size() != 0 || CNT !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_discard: got a_count %0d b_count %0d cnt %h expected 0 0 0",
               got[0].size(), got[1].size(), CNT);
    end
  endtask

  task automatic test_random();
    cycle(1'b0, 2'd0, 8'h00, 1'b0, 4'h0);
    clear_logs();
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 49) != 0), 2'($urandom), 8'($urandom),
            ($urandom_range(0, 9) < 7), 4'($urandom));
      checks++;
      if ({rdy_dut, VALID_OUT, Z, CNT} !== {rdy_exp, exp_v(), exp_z(), exp_cnt()}) begin
        errors++;
        $display("FAIL random_state[%0d]: got %h expected %h", i,
                 {rdy_dut, VALID_OUT, Z, CNT}, {rdy_exp, exp_v(), exp_z(), exp_cnt()});
      end
    end
    for (int i = 0; i < 2; i++) cycle(1'b1, 2'd0, 8'h00, 1'b0, 4'hF);
    for (int x = 0; x < 4; x++) begin
      checks++;
      if (got[x].size() != acc[x].size()) begin
        errors++;
        $display("FAIL random_count[%0d]: got %0d words expected %0d", x, got[x].size(), acc[x].size());
      end else begin
        for (int k = 0; k < got[x].size(); k++) begin
          checks++;
          if (got[x][k] !== acc[x][k]) begin
            errors++;
            $display("FAIL random_order[%0d][%0d]: got %h expected %h", x, k, got[x][k], acc[x][k]);
          end
        end
      end
    end
  endtask

  initial begin
    RST_N = 1'b0; S_IN = 2'd0; D_IN = 8'h00; VALID_IN = 1'b0; READY_OUT = 4'h0;
    for (int x = 0; x < 4; x++) begin
      m_last[x] = 8'h00;
      m_cnt[x]  = 0;
    end
    test_reset();
    test_routing();
    test_backpressure();
    test_streaming();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
